xbar_sat_scan: RTL
==================

// Module: xbar_sat_scan
// PURPOSE
//  Sequential driver and sampler for a combinational crossbar evaluator.
//  Enumerates every input assignment onto the crossbar literal inputs and waits a settle time.
//  Samples the crossbar output f and reports the first satisfying assignment (SAT/UNSAT).
//  Sits directly upstream of the crossbar (drives its literals) and consumes its f output.
// PARAMETERS
//  N_VARS        4  number of crossbar input literals; assignments 0 .. 2^N_VARS-1
//  SETTLE_CYCLES 2  cycles each assignment is held before f is sampled (legal range >=1)
// PORTS
//  clk        in   1         clock
//  rst        in   1         asynchronous reset, active-high
//  start      in   1         begin scan; honoured only in IDLE or DONE
//  xbar_in    out  N_VARS    assignment driven onto crossbar literals (bit i = literal i)
//  xbar_f     in   1         crossbar output f, combinational from xbar_in
//  busy       out  1         high while scanning
//  done       out  1         level; high from end of scan until next start
//  sat        out  1         valid when done: 1 = a satisfying assignment was found
//  model      out  N_VARS    valid when done&sat: first satisfying assignment (lowest value)
//  sol_count  out  N_VARS+1  number of satisfying assignments (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0; vec, settle counter and sol_count are 0; FSM = IDLE. Effect is immediate (async).
//  xbar_in is a register equal to vec; it changes only on clk edges.
//  FSM states and transitions:
//   IDLE:   start -> clear sat/model/sol_count, vec=0, settle=0 -> APPLY.
//   APPLY:  busy=1; settle++ each cycle; at settle==SETTLE_CYCLES-1 -> SAMPLE.
//   SAMPLE: busy=1; xbar_f sampled this cycle.
//           If xbar_f=1 and sat=0: sat<=1, model<=vec.
//           Stop: macro off and xbar_f=1 -> DONE.
//           Else if vec==2^N_VARS-1 -> DONE.
//           Else vec<=vec+1, settle<=0 -> APPLY.
//   DONE:   done=1, busy=0; start -> same action as in IDLE.
//  Each assignment costs exactly SETTLE_CYCLES+1 cycles.
//  Result latency for assignment v: done rises (v+1)*(SETTLE_CYCLES+1) edges after the start edge.
//  Boundary conditions:
//   - start while busy: ignored.
//   - start and rst together: rst wins.
//   - rst mid-scan: scan aborted, no partial results kept.
//   - vec never wraps; the scan ends at the all-ones assignment.
//   - xbar_f is ignored outside SAMPLE.
//   - A start in DONE drops done on the next edge.
// CONFIGURATION
//  Macro XSAT_SOLCOUNT_EN.
//  Defined:
//   - The scan never stops early; all 2^N_VARS assignments are evaluated.
//   - sol_count increments in every SAMPLE cycle with xbar_f=1 (saturation impossible at width N_VARS+1).
//   - sat and model still report the first hit.
//  Undefined:
//   - The scan stops at the first hit.
//   - sol_count is tied to 0.
// STRUCTURE
//  Package xsat_pkg holds:
//   - typedef enum scan_state_t {IDLE, APPLY, SAMPLE, DONE}
//   - function scan_cycles(n_vars, settle) returning the worst-case scan length, used by the bench.
//  Sub-module xbar_settle_timer (load/count/expire for SETTLE_CYCLES) is instantiated once.
//  The remaining logic (FSM, vec, results) stays in this module.
// TESTING
//  Bench: N_VARS=4, SETTLE_CYCLES=2; behavioural crossbar model f = xbar_in[0] & xbar_in[1].
//  1. SAT, macro off:
//     start -> xbar_in steps 0,1,2,3.
//     done at edge 12, sat=1, model=4'b0011, sol_count=0.
//  2. SAT, XSAT_SOLCOUNT_EN:
//     same stimulus -> 16 assignments.
//     done at edge 48, sat=1, model=4'b0011, sol_count=4.
//  3. UNSAT (model f=0):
//     done at edge 48, sat=0, model=0, xbar_in final value=4'b1111.
//  4. Reset mid-scan:
//     rst asserted during vec=2 -> all outputs 0 without waiting for a clock edge.
//     A following start rescans from vec=0.
//  5. Start handling:
//     start pulsed while busy -> no effect on timing.
//     start pulsed in DONE -> done=0 next cycle, results cleared, new scan identical to case 1.
//  6. f glitch check:
//     model f toggles during APPLY cycles and is 0 only in SAMPLE cycles -> sat=0 (only SAMPLE counts).

Source files
------------

// File: rtl/xbar_sat_scan_pkg.sv
// Shared types and helpers for the crossbar SAT scanner.
package xsat_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } scan_state_t;

  // Worst-case number of edges from the start edge until done rises.
  function automatic int scan_cycles(input int n_vars, input int settle);
    return (1 << n_vars) * (settle + 1);
  endfunction

endpackage

// File: rtl/xbar_sat_scan_if.sv
// Control, crossbar and result signals of the SAT scanner, grouped as one bundle.
interface xbar_sat_scan_if #(
  parameter int N_VARS = 4
);
  import xsat_pkg::*;

  // start has no ready: it is accepted on any edge where the scanner sits in
  // IDLE or DONE and silently dropped otherwise; busy/done report the outcome.
  logic              start;
  logic [N_VARS-1:0] xbar_in;
  logic              xbar_f;
  logic              busy;
  logic              done;
  logic              sat;
  logic [N_VARS-1:0] model;
  logic [N_VARS:0]   sol_count;
  scan_state_t       state;

  modport slave (
    input  start, xbar_f,
    output xbar_in, busy, done, sat, model, sol_count, state
  );

  modport master (
    output start, xbar_f,
    input  xbar_in, busy, done, sat, model, sol_count, state
  );

endinterface

// File: rtl/xbar_settle_timer.sv
// Settle timer: load clears it, each enabled cycle advances it, expire flags the last settle cycle.
module xbar_settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Holds at LAST; the FSM leaves APPLY on that cycle so further counting is moot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en && !expire) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expire = (cnt == LAST);

endmodule

// File: rtl/xbar_sat_scan.sv
// Walks every assignment onto a combinational crossbar, samples f after a settle time, reports SAT.
// XSAT_SOLCOUNT_EN: scan all assignments and count hits in sol_count instead of stopping at the first.
module xbar_sat_scan
  import xsat_pkg::*;
#(
  parameter int N_VARS        = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  xbar_sat_scan_if.slave   bus
);

  localparam logic [N_VARS-1:0] VEC_LAST = '1;

  scan_state_t       state, state_nx;
  logic [N_VARS-1:0] vec;
  logic              sat_r;
  logic [N_VARS-1:0] model_r;
  logic              tmr_load, tmr_en, tmr_expire;
  logic              begin_scan, step, hit;

  xbar_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .en    (tmr_en),
    .expire(tmr_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    tmr_load   = 1'b0;
    tmr_en     = 1'b0;
    begin_scan = 1'b0;
    step       = 1'b0;
    hit        = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          begin_scan = 1'b1;
          tmr_load   = 1'b1;
          state_nx   = APPLY;
        end
      end
      APPLY: begin
        tmr_en = 1'b1;
        if (tmr_expire) state_nx = SAMPLE;
      end
      SAMPLE: begin
        // f is only trusted here; anything it does while settling is ignored.
        hit = bus.xbar_f;
`ifdef XSAT_SOLCOUNT_EN
        if (vec == VEC_LAST) begin
          state_nx = DONE;
        end else begin
          step     = 1'b1;
          tmr_load = 1'b1;
          state_nx = APPLY;
        end
`else
        if (bus.xbar_f || vec == VEC_LAST) begin
          state_nx = DONE;
        end else begin
          step     = 1'b1;
          tmr_load = 1'b1;
          state_nx = APPLY;
        end
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec     <= '0;
      sat_r   <= 1'b0;
      model_r <= '0;
    end else begin
      if (begin_scan) begin
        vec     <= '0;
        sat_r   <= 1'b0;
        model_r <= '0;
      end
      if (step) vec <= vec + 1'b1;
      if (hit && !sat_r) begin
        sat_r   <= 1'b1;
        model_r <= vec;
      end
    end
  end

`ifdef XSAT_SOLCOUNT_EN
  logic [N_VARS:0] sol_cnt_r;

  // Width N_VARS+1 holds 2^N_VARS, so the count can never overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sol_cnt_r <= '0;
    end else if (begin_scan) begin
      sol_cnt_r <= '0;
    end else if (hit) begin
      sol_cnt_r <= sol_cnt_r + 1'b1;
    end
  end

  assign bus.sol_count = sol_cnt_r;
`else
  assign bus.sol_count = '0;
`endif

  assign bus.xbar_in = vec;
  assign bus.busy    = (state == APPLY) || (state == SAMPLE);
  assign bus.done    = (state == DONE);
  assign bus.sat     = sat_r;
  assign bus.model   = model_r;
  assign bus.state   = state;

endmodule
